// File: rtl/nx_ctrl_arbiter.sv
// Round-robin arbiter sharing the node store's control-block port between requesters.
// One access is granted per cycle, registered onto the store port, and read data is routed back to its issuer.
module nx_ctrl_arbiter #(
    parameter  int REQUESTERS = 3,
    parameter  int CTRL_WIDTH = 13,
    parameter  int MAX_CTRL   = 512,
    parameter  int RD_LATENCY = 1,
    localparam int ADDR_W     = $clog2(MAX_CTRL),
    localparam int IDX_W      = $clog2(REQUESTERS)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [REQUESTERS*ADDR_W-1:0]   req_addr_i,
    input  logic [REQUESTERS*CTRL_WIDTH-1:0] req_wr_data_i,
    input  logic [REQUESTERS-1:0]          req_wr_en_i,
    input  logic [REQUESTERS-1:0]          req_rd_en_i,
    output logic [REQUESTERS-1:0]          req_ready_o,
    output logic [REQUESTERS-1:0]          rsp_valid_o,
    output logic [CTRL_WIDTH-1:0]          rsp_data_o,
    output logic [ADDR_W-1:0]              ctrl_addr_o,
    output logic [CTRL_WIDTH-1:0]          ctrl_wr_data_o,
    output logic                           ctrl_wr_en_o,
    output logic                           ctrl_rd_en_o,
    input  logic [CTRL_WIDTH-1:0]          ctrl_rd_data_i
);

    logic [IDX_W-1:0]      last_q, last_d;
    logic [ADDR_W-1:0]     ctrl_addr_q, ctrl_addr_d;
    logic [CTRL_WIDTH-1:0] ctrl_wr_data_q, ctrl_wr_data_d;
    logic                  ctrl_wr_en_q, ctrl_wr_en_d;
    logic                  ctrl_rd_en_q, ctrl_rd_en_d;
    logic [REQUESTERS-1:0] track_q [RD_LATENCY+1];
    logic [REQUESTERS-1:0] track_d [RD_LATENCY+1];

    logic [REQUESTERS-1:0] req_any;
    logic [REQUESTERS-1:0] grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_vld;
    logic [IDX_W-1:0]      cand_idx [REQUESTERS];

    logic [ADDR_W-1:0]     sel_addr;
    logic [CTRL_WIDTH-1:0] sel_data;
    logic                  sel_wr;
    logic                  sel_rd;

    assign req_any = req_wr_en_i | req_rd_en_i;

    // Candidate gi is the (gi+1)-th index after the last winner, wrapped modulo REQUESTERS.
    generate
        for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum = {1'b0, last_q} + (IDX_W+1)'(gi + 1);
            assign cand_idx[gi] = (sum >= (IDX_W+1)'(REQUESTERS)) ?
                                  IDX_W'(sum - (IDX_W+1)'(REQUESTERS)) : IDX_W'(sum);
        end
    endgenerate

    always_comb begin
        grant     = '0;
        grant_idx = last_q;
        grant_vld = 1'b0;
        for (int k = 0; k < REQUESTERS; k++) begin
            if (!grant_vld && req_any[cand_idx[k]]) begin
                grant_vld = 1'b1;
                grant_idx = cand_idx[k];
            end
        end
        if (rst_i) begin
            grant_vld = 1'b0;
        end
        if (grant_vld) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign req_ready_o = grant;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_wr   = 1'b0;
        sel_rd   = 1'b0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr_i[i*ADDR_W +: ADDR_W];
                sel_data = req_wr_data_i[i*CTRL_WIDTH +: CTRL_WIDTH];
                sel_wr   = req_wr_en_i[i];
                sel_rd   = req_rd_en_i[i];
            end
        end
    end

    // A write wins over a simultaneous read from the same requester; the read is dropped.
    always_comb begin
        last_d         = grant_vld ? grant_idx : last_q;
        ctrl_wr_en_d   = sel_wr;
        ctrl_rd_en_d   = sel_rd & ~sel_wr;
        ctrl_addr_d    = sel_addr;
        ctrl_wr_data_d = sel_wr ? sel_data : '0;
        track_d[0]     = ctrl_rd_en_d ? grant : '0;
    end

    generate
        for (genvar gi = 1; gi <= RD_LATENCY; gi++) begin : g_track
            assign track_d[gi] = track_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q         <= IDX_W'(REQUESTERS - 1);
            ctrl_addr_q    <= '0;
            ctrl_wr_data_q <= '0;
            ctrl_wr_en_q   <= 1'b0;
            ctrl_rd_en_q   <= 1'b0;
            for (int s = 0; s <= RD_LATENCY; s++) begin
                track_q[s] <= '0;
            end
        end else begin
            last_q         <= last_d;
            ctrl_addr_q    <= ctrl_addr_d;
            ctrl_wr_data_q <= ctrl_wr_data_d;
            ctrl_wr_en_q   <= ctrl_wr_en_d;
            ctrl_rd_en_q   <= ctrl_rd_en_d;
            for (int s = 0; s <= RD_LATENCY; s++) begin
                track_q[s] <= track_d[s];
            end
        end
    end

    assign ctrl_addr_o    = ctrl_addr_q;
    assign ctrl_wr_data_o = ctrl_wr_data_q;
    assign ctrl_wr_en_o   = ctrl_wr_en_q;
    assign ctrl_rd_en_o   = ctrl_rd_en_q;

    // Stage 0 lines up with ctrl_rd_en_o, so stage RD_LATENCY lines up with valid store data.
    assign rsp_valid_o = track_q[RD_LATENCY];
    assign rsp_data_o  = (|track_q[RD_LATENCY]) ? ctrl_rd_data_i : '0;

endmodule

// File: tb/tb_nx_ctrl_arbiter.sv
// Bench for nx_ctrl_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (round-robin pick, shadow memory, expected responses by cycle).
module tb_nx_ctrl_arbiter;

    localparam int R    = 3;
    localparam int CW   = 13;
    localparam int MC   = 512;
    localparam int AW   = 9;
    localparam int RDL  = 1;
    localparam int MAXC = 1024;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [R*AW-1:0] req_addr;
    logic [R*CW-1:0] req_wr_data;
    logic [R-1:0]    req_wr_en;
    logic [R-1:0]    req_rd_en;
    logic [R-1:0]    req_ready;
    logic [R-1:0]    rsp_valid;
    logic [CW-1:0]   rsp_data;
    logic [AW-1:0]   ctrl_addr;
    logic [CW-1:0]   ctrl_wr_data;
    logic            ctrl_wr_en;
    logic            ctrl_rd_en;
    logic [CW-1:0]   ctrl_rd_data = '0;

    nx_ctrl_arbiter #(
        .REQUESTERS(R), .CTRL_WIDTH(CW), .MAX_CTRL(MC), .RD_LATENCY(RDL)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_addr_i     (req_addr),
        .req_wr_data_i  (req_wr_data),
        .req_wr_en_i    (req_wr_en),
        .req_rd_en_i    (req_rd_en),
        .req_ready_o    (req_ready),
        .rsp_valid_o    (rsp_valid),
        .rsp_data_o     (rsp_data),
        .ctrl_addr_o    (ctrl_addr),
        .ctrl_wr_data_o (ctrl_wr_data),
        .ctrl_wr_en_o   (ctrl_wr_en),
        .ctrl_rd_en_o   (ctrl_rd_en),
        .ctrl_rd_data_i (ctrl_rd_data)
    );

    always #5 clk = ~clk;

    // Requester-side stimulus state
    logic          b_wr   [R];
    logic          b_rd   [R];
    logic [AW-1:0] b_addr [R];
    logic [CW-1:0] b_data [R];

    always_comb begin
        req_addr    = '0;
        req_wr_data = '0;
        req_wr_en   = '0;
        req_rd_en   = '0;
        for (int i = 0; i < R; i++) begin
            req_addr[i*AW +: AW]    = b_addr[i];
            req_wr_data[i*CW +: CW] = b_data[i];
            req_wr_en[i]            = b_wr[i];
            req_rd_en[i]            = b_rd[i];
        end
    end

    function automatic logic [CW-1:0] init_val(input int a);
        if (a == 10) return 13'h000A;
        if (a == 11) return 13'h000B;
        if (a == 12) return 13'h000C;
        return CW'((a * 37 + 5) & 13'h1FFF);
    endfunction

    // Store behaviour: registered read, one-cycle latency
    logic [CW-1:0] store_mem [MC];
    initial begin
        for (int a = 0; a < MC; a++) store_mem[a] = init_val(a);
        forever begin
            @(posedge clk);
            if (ctrl_wr_en) store_mem[ctrl_addr] <= ctrl_wr_data;
            if (ctrl_rd_en) ctrl_rd_data <= store_mem[ctrl_addr];
        end
    end

    // Reference model state
    logic [CW-1:0] ref_mem   [MC];
    logic [R-1:0]  exp_rsp_v [MAXC];
    logic [CW-1:0] exp_rsp_d [MAXC];
    int            last_m;
    int            granted_idx;
    int            cyc;
    logic          e_wr, e_rd;
    logic [AW-1:0] e_addr;
    logic [CW-1:0] e_data;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        logic [R-1:0]  req, exp_rdy;
        logic          n_wr, n_rd;
        logic [AW-1:0] n_addr;
        logic [CW-1:0] n_data;
        int            g;
        @(negedge clk);
        for (int i = 0; i < R; i++) req[i] = b_wr[i] | b_rd[i];
        g = -1;
        exp_rdy = '0;
        if (!rst) begin
            for (int k = 1; k <= R; k++) begin
                if (g < 0 && req[(last_m + k) % R]) g = (last_m + k) % R;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;

        check_val("ready",   32'(req_ready),    32'(exp_rdy));
        check_val("wr_en",   32'(ctrl_wr_en),   32'(e_wr));
        check_val("rd_en",   32'(ctrl_rd_en),   32'(e_rd));
        check_val("addr",    32'(ctrl_addr),    32'(e_addr));
        check_val("wr_data", 32'(ctrl_wr_data), 32'(e_data));
        check_val("rsp_vld", 32'(rsp_valid),    32'(exp_rsp_v[cyc]));
        check_val("rsp_dat", 32'(rsp_data),
                  (exp_rsp_v[cyc] != '0) ? 32'(exp_rsp_d[cyc]) : 32'd0);

        n_wr = 1'b0; n_rd = 1'b0; n_addr = '0; n_data = '0;
        if (rst) begin
            last_m = R - 1;
            for (int c = cyc + 1; c < MAXC; c++) exp_rsp_v[c] = '0;
        end else if (g >= 0) begin
            last_m = g;
            n_addr = b_addr[g];
            if (b_wr[g]) begin
                n_wr = 1'b1;
                n_data = b_data[g];
                ref_mem[b_addr[g]] = b_data[g];
                $display("cyc %0d grant r%0d write addr=%0d data=%h", cyc, g, b_addr[g], b_data[g]);
            end else begin
                n_rd = 1'b1;
                exp_rsp_v[cyc + 1 + RDL][g] = 1'b1;
                exp_rsp_d[cyc + 1 + RDL] = ref_mem[b_addr[g]];
                $display("cyc %0d grant r%0d read  addr=%0d expect=%h", cyc, g, b_addr[g], ref_mem[b_addr[g]]);
            end
        end
        granted_idx = g;
        @(posedge clk);
        e_wr = n_wr; e_rd = n_rd; e_addr = n_addr; e_data = n_data;
        cyc++;
        #1;
    endtask

    task automatic drop(input int i);
        b_wr[i] = 1'b0;
        b_rd[i] = 1'b0;
    endtask

    task automatic set_req(input int i, input logic wr, input logic rd,
                           input int a, input logic [CW-1:0] d);
        b_wr[i] = wr;
        b_rd[i] = rd;
        b_addr[i] = AW'(a);
        b_data[i] = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < R; i++) drop(i);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        for (int a = 0; a < MC; a++) ref_mem[a] = init_val(a);
        for (int c = 0; c < MAXC; c++) begin
            exp_rsp_v[c] = '0;
            exp_rsp_d[c] = '0;
        end
        for (int i = 0; i < R; i++) set_req(i, 1'b0, 1'b0, 0, '0);
        last_m = R - 1; cyc = 0; granted_idx = -1;
        e_wr = 1'b0; e_rd = 1'b0; e_addr = '0; e_data = '0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset with everyone requesting, then continuous round-robin reads of 10/11/12
        for (int i = 0; i < R; i++) set_req(i, 1'b0, 1'b1, 10 + i, '0);
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) step();
        idle(3);

        // Lone write from requester 1
        set_req(1, 1'b1, 1'b0, 5, 13'h1ABC);
        step(); drop(1);
        idle(2);

        // Write then read of the same address in the very next cycle
        set_req(0, 1'b1, 1'b0, 7, 13'h0055);
        step(); drop(0);
        set_req(2, 1'b0, 1'b1, 7, '0);
        step(); drop(2);
        idle(3);

        // Write and read together: only the write happens
        set_req(2, 1'b1, 1'b1, 3, 13'h0123);
        step(); drop(2);
        step();
        set_req(1, 1'b0, 1'b1, 3, '0);
        step(); drop(1);
        idle(3);

        // Read in flight when reset hits; requester 0 first after release
        set_req(1, 1'b0, 1'b1, 20, '0);
        step(); drop(1);
        for (int i = 0; i < R; i++) set_req(i, 1'b0, 1'b1, 30 + i, '0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step(); drop(granted_idx);
        step(); drop(granted_idx);
        idle(3);

        // Randomized traffic with occasional resets
        for (int t = 0; t < 500; t++) begin
            for (int i = 0; i < R; i++) begin
                if (!(b_wr[i] | b_rd[i]) && $urandom_range(0, 1) == 1) begin
                    int kind;
                    kind = int'($urandom_range(0, 19));
                    set_req(i, kind >= 9, kind < 11, int'($urandom_range(0, 15)),
                            CW'($urandom));
                end
            end
            rst = ($urandom_range(0, 59) == 0);
            step();
            if (granted_idx >= 0) drop(granted_idx);
        end
        rst = 1'b0;
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/nx_ctrl_arbiter.md
Name: nx_ctrl_arbiter

Overview:
Round-robin arbiter that shares the node store's single control-block port (addr / wr_data / wr_en / rd_en / rd_data) between several requesters, e.g. message decoder configuration writes, the output-mapping lookup and debug readback. It grants one access per cycle and registers the winning access onto the store port. It tracks in-flight reads and routes each read response back to the requester that issued it.

Parameters:
REQUESTERS, 3, number of requesters sharing the control port (2..8)
CTRL_WIDTH, 13, width of each control entry
MAX_CTRL, 512, control entries in the store; ADDR_W = $clog2(MAX_CTRL)
RD_LATENCY, 1, cycles from store ctrl_rd_en_o to valid ctrl_rd_data_i (>=1)

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
req_addr_i  input  REQUESTERS*ADDR_W  per-requester address, requester i at slice [i*ADDR_W +: ADDR_W]
req_wr_data_i  input  REQUESTERS*CTRL_WIDTH  per-requester write data
req_wr_en_i  input  REQUESTERS  per-requester write request
req_rd_en_i  input  REQUESTERS  per-requester read request
req_ready_o  output  REQUESTERS  one-hot grant; access accepted when request && ready
rsp_valid_o  output  REQUESTERS  one-hot read response valid
rsp_data_o  output  CTRL_WIDTH  read response data, shared by all requesters
ctrl_addr_o  output  ADDR_W  to store ctrl_addr_i
ctrl_wr_data_o  output  CTRL_WIDTH  to store ctrl_wr_data_i
ctrl_wr_en_o  output  1  to store ctrl_wr_en_i
ctrl_rd_en_o  output  1  to store ctrl_rd_en_i
ctrl_rd_data_i  input  CTRL_WIDTH  from store ctrl_rd_data_o

Behaviour:
- Request from i: req_wr_en_i[i] | req_rd_en_i[i]. Requesters hold addr, data and enables stable until granted.
- Grant is combinational in the same cycle (cycle N).
  - Search starts at last_q+1 and wraps modulo REQUESTERS; the first requesting index wins.
  - req_ready_o is one-hot on that index, or all-zero when no requests.
  - Grant never depends on the store (store port always accepts).
- last_q updates to the granted index on a grant and holds otherwise. Reset value is REQUESTERS-1, so requester 0 has first priority after reset.
- Store outputs are registered. They carry the granted access in cycle N+1.
  - Idle cycle: ctrl_wr_en_o=0, ctrl_rd_en_o=0, ctrl_addr_o=0, ctrl_wr_data_o=0.
- Both wr_en and rd_en high on the granted requester: only the write is issued, the read is dropped, and no response is returned.
- Read tracking: shift register of RD_LATENCY+1 stages carrying the one-hot requester ID of each issued read.
  - rsp_valid_o[i] asserts in cycle N+1+RD_LATENCY for a read granted to i in cycle N.
  - rsp_data_o = ctrl_rd_data_i while any rsp_valid_o bit is set, else 0.
- Throughput: one access per cycle. Back-to-back reads from any mix of requesters pipeline with no bubbles. A write granted in cycle N is visible to a read granted in cycle N+1 or later (store writes before the following read).
- Same requester granted in consecutive cycles only when it is the sole requester.
- Reset (any time, including with reads in flight):
  - All outputs 0 in the cycle after rst_i is sampled.
  - last_q = REQUESTERS-1; tracking pipeline cleared.
  - In-flight reads are discarded and produce no rsp_valid_o.
  - req_ready_o is forced 0 while rst_i is high.
- Requests with addr >= MAX_CTRL (non-power-of-2 MAX_CTRL) are passed through unchanged; range checking belongs to the requester.

Test Plan:
1. Assert rst_i 2 cycles with all requests high -> req_ready_o=0 throughout; one cycle after release, requester 0 granted first; all store outputs and rsp_valid_o 0 during reset.
2. Requester 1 alone writes addr 5 data 0x1ABC -> req_ready_o=3'b010 in cycle N; cycle N+1 ctrl_wr_en_o=1, ctrl_addr_o=5, ctrl_wr_data_o=0x1ABC; no rsp_valid_o.
3. All three requesters continuously read addrs 10/11/12 with preloaded store values 0x0A/0x0B/0x0C -> grants 0,1,2,0,1,2; rsp_valid_o one-hot follows each grant by 2 cycles (RD_LATENCY=1) with matching data; no bubbles.
4. Requester 0 writes addr 7=0x0055, then requester 2 reads addr 7 one cycle later -> rsp_valid_o=3'b100 with rsp_data_o=0x0055.
5. Requester 2 asserts wr_en and rd_en together, addr 3, data 0x0123 -> one write issued, ctrl_rd_en_o=0, no response; a later read of addr 3 returns 0x0123.
6. Requester 1 read granted, rst_i asserted the next cycle -> no rsp_valid_o at any point; requester 0 wins first grant after release.
